// File: rtl/alu_result_reader_pkg.sv
// Shared types and constants for the ALU result history reader.
package alu_result_reader_pkg;

   // Display mode: live ALU output or scrolling through stored history
   typedef enum logic {
      ST_LIVE   = 1'b0,
      ST_BROWSE = 1'b1
   } state_e;

   // Board-level key lockout: 10 ms at 50 MHz
   localparam int unsigned BOARD_LOCKOUT = 500000;

   // Board ALU width and the matching stored entry width ({zero, result})
   localparam int unsigned BOARD_WIDTH   = 4;
   localparam int unsigned BOARD_ENTRY_W = BOARD_WIDTH + 1;

   // Stored entry width for a given ALU result width
   function automatic int unsigned entry_width(input int unsigned w);
      return w + 1;
   endfunction

endpackage

// File: rtl/alu_result_reader_key_press_detector.sv
// Raw active-low key to single-cycle accepted press pulse, with lockout.
module key_press_detector
   import alu_result_reader_pkg::*;
#(
   parameter int unsigned LOCKOUT = BOARD_LOCKOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic press_c
);

   localparam int unsigned LK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            prev_q,  prev_d;
   logic [LK_W-1:0] lock_q,  lock_d;
   logic            edge_c;

   // Falling edge of the synchronized key, gated by the lockout window
   always_comb begin
      edge_c  = prev_q & ~sync2_q;
      press_c = edge_c && (lock_q == '0);
   end

   // Next-state for synchronizer chain and lockout counter
   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      lock_d  = lock_q;
      if (press_c) begin
         lock_d = LK_W'(LOCKOUT - 1);
      end else if (lock_q != '0) begin
         lock_d = lock_q - LK_W'(1);
      end
   end

   // Key path registers; synchronizer resets to the released level
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         lock_q  <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         lock_q  <= lock_d;
      end
   end

endmodule

// File: rtl/alu_result_reader.sv
// Captures ALU {zero, result} into a circular history and scrolls it on LEDs.
module alu_result_reader
   import alu_result_reader_pkg::*;
#(
   parameter int unsigned WIDTH   = BOARD_WIDTH,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LOCKOUT = BOARD_LOCKOUT
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           result,
   input  logic                       zero,
   input  logic                       capture_n,
   input  logic                       step_n,
   output logic [WIDTH-1:0]           view_result,
   output logic                       view_zero,
   output logic [$clog2(DEPTH)-1:0]   view_age,
   output logic                       browse,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full
);

   localparam int unsigned ENTRY_W = entry_width(WIDTH);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

   logic               cap_c;
   logic               step_c;
   logic [ENTRY_W-1:0] live_c;
   logic [PTR_W-1:0]   rd_idx_c;

   state_e             state_q,  state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [PTR_W-1:0]   age_q,    age_d;
   logic [ENTRY_W-1:0] view_q,   view_d;
   logic               full_q,   full_d;
   logic [ENTRY_W-1:0] hist_q [DEPTH];

   // Capture key
   key_press_detector #(.LOCKOUT(LOCKOUT)) u_cap_key (
      .clock   (clock),
      .reset   (reset),
      .key_n   (capture_n),
      .press_c (cap_c)
   );

   // Browse/step key
   key_press_detector #(.LOCKOUT(LOCKOUT)) u_step_key (
      .clock   (clock),
      .reset   (reset),
      .key_n   (step_n),
      .press_c (step_c)
   );

   // Mode, pointer, occupancy and displayed entry; capture beats step
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      age_d    = age_q;
      live_c   = {zero, result};

      if (cap_c) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (count_q != CNT_W'(DEPTH)) begin
            count_d = count_q + CNT_W'(1);
         end
         state_d = ST_LIVE;
         age_d   = '0;
      end else if (step_c) begin
         case (state_q)
            ST_LIVE: begin
               if (count_q != '0) begin
                  state_d = ST_BROWSE;
                  age_d   = '0;
               end
            end
            ST_BROWSE: begin
               if (CNT_W'(age_q) == count_q - CNT_W'(1)) begin
                  state_d = ST_LIVE;
                  age_d   = '0;
               end else begin
                  age_d = age_q + PTR_W'(1);
               end
            end
            default: begin
               state_d = ST_LIVE;
               age_d   = '0;
            end
         endcase
      end

      // Display tracks the post-update mode so it agrees with browse/view_age
      rd_idx_c = wr_ptr_q - PTR_W'(1) - age_d;
      if (state_d == ST_BROWSE) begin
         view_d = hist_q[rd_idx_c];
      end else begin
         view_d = live_c;
      end
      full_d = (count_d == CNT_W'(DEPTH));
   end

   // Control and display registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_LIVE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         age_q    <= '0;
         view_q   <= '0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         age_q    <= age_d;
         view_q   <= view_d;
         full_q   <= full_d;
      end
   end

   // History storage; contents are meaningless until counted valid
   always_ff @(posedge clock) begin
      if (cap_c) begin
         hist_q[wr_ptr_q] <= live_c;
      end
   end

   assign view_result = view_q[WIDTH-1:0];
   assign view_zero   = view_q[ENTRY_W-1];
   assign view_age    = age_q;
   assign browse      = (state_q == ST_BROWSE);
   assign count       = count_q;
   assign full        = full_q;

endmodule

// File: tb/tb_alu_result_reader.sv
// Directed bench for alu_result_reader (WIDTH=4, DEPTH=4, LOCKOUT=4).
module tb_alu_result_reader;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] result;
   logic       zero;
   logic       capture_n;
   logic       step_n;
   logic [3:0] view_result;
   logic       view_zero;
   logic [1:0] view_age;
   logic       browse;
   logic [2:0] count;
   logic       full;

   int n_pass  = 0;
   int n_total = 0;

   alu_result_reader #(.WIDTH(4), .DEPTH(4), .LOCKOUT(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .result      (result),
      .zero        (zero),
      .capture_n   (capture_n),
      .step_n      (step_n),
      .view_result (view_result),
      .view_zero   (view_zero),
      .view_age    (view_age),
      .browse      (browse),
      .count       (count),
      .full        (full)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Gap for lockout, then a one-sample key press; returns after the acting edge
   task automatic press(input logic cap, input logic stp);
      repeat (2) tick();
      if (cap) capture_n = 1'b0;
      if (stp) step_n = 1'b0;
      tick();
      capture_n = 1'b1;
      step_n    = 1'b1;
      tick();
      tick();
   endtask

   task automatic capture_val(input logic [3:0] r, input logic z);
      result = r;
      zero   = z;
      press(1'b1, 1'b0);
   endtask

   task automatic check_view(input string tag, input logic [3:0] r, input logic z,
                             input logic [1:0] a, input logic b);
      check({tag, "_result"}, 32'(view_result), 32'(r));
      check({tag, "_zero"},   32'(view_zero),   32'(z));
      check({tag, "_age"},    32'(view_age),    32'(a));
      check({tag, "_browse"}, 32'(browse),      32'(b));
   endtask

   initial begin
      reset     = 1'b0;
      result    = 4'h0;
      zero      = 1'b0;
      capture_n = 1'b1;
      step_n    = 1'b1;

      // Reset state
      repeat (3) tick();
      check_view("rst", 4'h0, 1'b0, 2'd0, 1'b0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full",  32'(full),  32'd0);
      reset = 1'b1;
      tick();
      check_view("rst_rel", 4'h0, 1'b0, 2'd0, 1'b0);

      // Live pass-through, one cycle latency
      result = 4'h5;
      zero   = 1'b0;
      check("live_before", 32'(view_result), 32'd0);
      tick();
      check_view("live5", 4'h5, 1'b0, 2'd0, 1'b0);
      result = 4'h9;
      zero   = 1'b1;
      tick();
      check_view("live9", 4'h9, 1'b1, 2'd0, 1'b0);

      // Step with empty history is ignored
      press(1'b0, 1'b1);
      check("empty_step_browse", 32'(browse), 32'd0);
      check("empty_step_count",  32'(count),  32'd0);

      // Capture three entries, then scroll newest first
      capture_val(4'h3, 1'b0);
      capture_val(4'h0, 1'b1);
      capture_val(4'h5, 1'b0);
      check("cap3_count", 32'(count), 32'd3);
      check("cap3_full",  32'(full),  32'd0);
      check_view("cap3_live", 4'h5, 1'b0, 2'd0, 1'b0);
      result = 4'hF;
      zero   = 1'b1;
      press(1'b0, 1'b1);
      check_view("br_age0", 4'h5, 1'b0, 2'd0, 1'b1);
      press(1'b0, 1'b1);
      check_view("br_age1", 4'h0, 1'b1, 2'd1, 1'b1);
      press(1'b0, 1'b1);
      check_view("br_age2", 4'h3, 1'b0, 2'd2, 1'b1);
      press(1'b0, 1'b1);
      check_view("br_back_live", 4'hF, 1'b1, 2'd0, 1'b0);

      // Wrap-around: six more captures overwrite the oldest
      for (int v = 1; v <= 6; v++) capture_val(4'(v), 1'b0);
      check("wrap_count", 32'(count), 32'd4);
      check("wrap_full",  32'(full),  32'd1);
      result = 4'hC;
      zero   = 1'b1;
      press(1'b0, 1'b1);
      check_view("wrap_age0", 4'h6, 1'b0, 2'd0, 1'b1);
      press(1'b0, 1'b1);
      check_view("wrap_age1", 4'h5, 1'b0, 2'd1, 1'b1);
      press(1'b0, 1'b1);
      check_view("wrap_age2", 4'h4, 1'b0, 2'd2, 1'b1);
      press(1'b0, 1'b1);
      check_view("wrap_age3", 4'h3, 1'b0, 2'd3, 1'b1);
      press(1'b0, 1'b1);
      check_view("wrap_live", 4'hC, 1'b1, 2'd0, 1'b0);
      check("wrap_count_kept", 32'(count), 32'd4);

      // Reset mid-browse takes effect without a clock edge
      press(1'b0, 1'b1);
      check("pre_rst_browse", 32'(browse), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_count",  32'(count),  32'd0);
      check("midrst_browse", 32'(browse), 32'd0);
      check("midrst_full",   32'(full),   32'd0);
      check("midrst_view",   32'(view_result), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Bounce: several falling edges inside the lockout yield one write at N+2
      result = 4'h7;
      zero   = 1'b1;
      repeat (2) tick();
      capture_n = 1'b0;          // sampled low at edge N
      tick();
      capture_n = 1'b1;          // sampled high at edge N+1
      check("bounce_n0", 32'(count), 32'd0);
      tick();
      capture_n = 1'b0;          // sampled low at edge N+2
      check("bounce_n1", 32'(count), 32'd0);
      tick();
      check("bounce_n2", 32'(count), 32'd1);
      #2 capture_n = 1'b1;       // glitch between samples
      #2 capture_n = 1'b0;
      tick();
      capture_n = 1'b1;
      repeat (6) tick();
      check("bounce_final", 32'(count), 32'd1);

      // Collision in BROWSE age1: capture wins
      capture_val(4'h2, 1'b0);
      check("col_pre_count", 32'(count), 32'd2);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      check_view("col_age1", 4'h7, 1'b1, 2'd1, 1'b1);
      result = 4'hA;
      zero   = 1'b0;
      press(1'b1, 1'b1);
      check("col_count", 32'(count), 32'd3);
      check_view("col_live", 4'hA, 1'b0, 2'd0, 1'b0);
      result = 4'h1;
      zero   = 1'b1;
      press(1'b0, 1'b1);
      check_view("col_newest", 4'hA, 1'b0, 2'd0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
